conf_add_sched: RTL and testbench
=================================

# conf_add_sched

Round-robin scheduler that shares one combinational configurable-approximation integer adder (`conf_int_add__noFF__multiple_add`) among `NUM_REQ` requesters. Each request carries two operands and a 3-bit accuracy configuration. The scheduler serialises requests onto the adder, drives the adder's `conf_select` for each operation, and returns the registered sum tagged with the requester id. It sits between the approximate-compute clients and the single adder instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `OP_BITWIDTH`, 32: operand and result width.
- `DATA_PATH_BITWIDTH`, 32: passed unchanged to the adder instance parameters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester accept; one-hot or zero.
- `req_a` in `NUM_REQ*OP_BITWIDTH`: operand a, requester k at slice k.
- `req_b` in `NUM_REQ*OP_BITWIDTH`: operand b, same packing.
- `req_conf` in `NUM_REQ*3`: requested `conf_select`, same packing.
- `add_a`, `add_b` out `OP_BITWIDTH`: operands to the adder.
- `add_conf_select` out 3: configuration to the adder.
- `add_c` in `OP_BITWIDTH`: adder result, combinational from `add_a`/`add_b`.
- `resp_valid` out 1: response valid.
- `resp_ready` in 1: response consumer ready.
- `resp_id` out `clog2(NUM_REQ)`: index of the requester that owns the response.
- `resp_data` out `OP_BITWIDTH`: registered sum.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, SETTLE (only with the macro), EXEC, RESP.
- IDLE: if any `req_valid` is high, grant the first valid requester at or after `rr_ptr`, searching upward with wrap. Assert `req_ready[g]` combinationally in the same cycle. On that edge:
  - latch operands, conf and id into `op_a`, `op_b`, `op_conf`, `op_id`;
  - move to EXEC, or to SETTLE if that path applies.
- `req_ready` is zero in every state other than IDLE. Requesters must hold request fields stable while valid and not ready.
- EXEC: `add_a`, `add_b` and `add_conf_select` are driven from the op registers. At the edge, capture `add_c` into `resp_data`, set `last_conf <= op_conf`, and move to RESP.
- RESP: `resp_valid`=1, with `resp_id`=`op_id`. When `resp_ready`=1, set `rr_ptr <= (op_id+1) mod NUM_REQ` and move to IDLE. Otherwise hold every output.
- Arithmetic: the sum is truncated to `OP_BITWIDTH` with no carry-out, exactly as the adder returns it. The scheduler never modifies the value.
- Outside EXEC and SETTLE, the `add_*` outputs hold their last driven values and are don't-care to the adder.
- Reset values: state IDLE, `rr_ptr`=0, `last_conf`=0, all op registers 0. Outputs: `req_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_id`=0, `busy`=0, `add_a`/`add_b`/`add_conf_select`=0.
- `rst` asserted in any state aborts the in-flight operation. No response is produced and no requester is re-accepted implicitly.

## Timing
- Request accepted at edge T (IDLE, `req_valid` & `req_ready`). EXEC runs in cycle T+1. `resp_valid` rises at T+2.
- Peak throughput is one operation per 3 cycles when `resp_ready` is tied high.
- A new grant is possible in the cycle after the RESP handshake, never in the same cycle.
- Backpressure: RESP holds for any number of cycles, and no further request is accepted meanwhile.
- With SETTLE taken, latency is T+3.

## Configuration
- Macro: `CONF_ADD_SCHED_SETTLE_EN`.
- Defined: when the granted `req_conf` differs from `last_conf`, IDLE goes to SETTLE instead of EXEC.
  - SETTLE drives the new `add_conf_select` and operands for one cycle with no capture, then moves to EXEC.
  - This covers adder reconfiguration settling in the synthesized netlist.
- Undefined: the SETTLE state and the comparison logic are absent, and IDLE always goes to EXEC.

## Structure
- Package `conf_add_pkg` holds:
  - `CONF_W`=3;
  - the state enum `sched_state_t` {IDLE, SETTLE, EXEC, RESP};
  - the function `id_w(n)` returning `clog2(n)`, minimum 1.
- Sub-module `rr_arbiter`: combinational. Takes `req[NUM_REQ]` and `ptr`, returns one-hot `gnt` and binary `gnt_id`. The scheduler owns `rr_ptr`.
- The adder itself is instantiated outside the scheduler, at the parent level.

## Test plan
- Single request, reqs 0, `a`=5, `b`=7, conf 1, `resp_ready`=1 → `resp_valid` two cycles after accept, `resp_data`=12, `resp_id`=0, `add_conf_select`=1 during EXEC.
- All four requesters valid continuously from reset → grants in order 0,1,2,3,0. Each `resp_id` matches, and no requester is starved.
- Overflow: `a`=0xFFFFFFFF, `b`=1 → `resp_data`=0 (truncated).
- `resp_ready` held low 5 cycles in RESP → `resp_valid`, `resp_data` and `resp_id` stable, `req_ready`=0 throughout. On release, the next grant comes one cycle later.
- `rst` pulsed during EXEC → all outputs return to reset values next cycle, no response, and `rr_ptr`=0 afterwards.
- With `CONF_ADD_SCHED_SETTLE_EN`: back-to-back requests with conf 1 then 1 → no SETTLE. Then a conf 2 request → one extra cycle, with `resp_valid` at T+3.

Source files
------------

// File: rtl/conf_add_sched_pkg.sv
// rtl/conf_add_sched_pkg.sv - shared types, widths and helpers for the adder scheduler
package conf_add_pkg;

  // Width of the adder's accuracy configuration select.
  localparam int CONF_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EXEC   = 2'd2,
    RESP   = 2'd3
  } sched_state_t;

  // Requester-id width; never narrower than one bit.
  function automatic int id_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/conf_add_sched_if.sv
// rtl/conf_add_sched_if.sv - request, adder and response signal bundle for the scheduler
interface conf_add_sched_if #(
  parameter int NUM_REQ     = 4,
  parameter int OP_BITWIDTH = 32
);
  import conf_add_pkg::*;

  localparam int ID_W = id_w(NUM_REQ);

  // Requester side, requester k at slice k.
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*OP_BITWIDTH-1:0] req_a;
  logic [NUM_REQ*OP_BITWIDTH-1:0] req_b;
  logic [NUM_REQ*CONF_W-1:0]      req_conf;

  // Shared adder; add_c is combinational from add_a/add_b.
  logic [OP_BITWIDTH-1:0]         add_a;
  logic [OP_BITWIDTH-1:0]         add_b;
  logic [CONF_W-1:0]              add_conf_select;
  logic [OP_BITWIDTH-1:0]         add_c;

  // Response side.
  logic                           resp_valid;
  logic                           resp_ready;
  logic [ID_W-1:0]                resp_id;
  logic [OP_BITWIDTH-1:0]         resp_data;

  modport slave (
    input  req_valid, req_a, req_b, req_conf, add_c, resp_ready,
    output req_ready, add_a, add_b, add_conf_select, resp_valid, resp_id, resp_data
  );

  modport master (
    output req_valid, req_a, req_b, req_conf, add_c, resp_ready,
    input  req_ready, add_a, add_b, add_conf_select, resp_valid, resp_id, resp_data
  );

endinterface

// File: rtl/conf_add_sched_rr_arbiter.sv
// rtl/conf_add_sched_rr_arbiter.sv - combinational round-robin grant starting at a pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  // Pick the first active requester at or after ptr, searching upward with wrap.
  always_comb begin
    int          idx;
    logic [ID_W-1:0] sel;
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ID_W'(idx);
      if (!any && req[sel]) begin
        any      = 1'b1;
        gnt[sel] = 1'b1;
        gnt_id   = sel;
      end
    end
  end

endmodule

// File: rtl/conf_add_sched.sv
// rtl/conf_add_sched.sv - round-robin scheduler sharing one adder; CONF_ADD_SCHED_SETTLE_EN adds a reconfiguration settle cycle
module conf_add_sched
  import conf_add_pkg::*;
#(
  parameter int NUM_REQ            = 4,
  parameter int OP_BITWIDTH        = 32,
  parameter int DATA_PATH_BITWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  conf_add_sched_if.slave   bus,
  output logic              busy
);

  localparam int ID_W = id_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_PATH_BITWIDTH < 1) begin : g_param_check
    $error("conf_add_sched: unsupported parameter set");
  end

  sched_state_t           state;
  sched_state_t           state_nxt;

  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        ptr_next;
  logic [NUM_REQ-1:0]     gnt;
  logic [ID_W-1:0]        gnt_id;
  logic                   gnt_any;

  logic [OP_BITWIDTH-1:0] gnt_a;
  logic [OP_BITWIDTH-1:0] gnt_b;
  logic [CONF_W-1:0]      gnt_conf;

  logic [OP_BITWIDTH-1:0] op_a;
  logic [OP_BITWIDTH-1:0] op_b;
  logic [CONF_W-1:0]      op_conf;
  logic [ID_W-1:0]        op_id;
  logic [OP_BITWIDTH-1:0] resp_data_q;

  logic                   accept;
  logic                   capture;
  logic                   release_resp;

`ifdef CONF_ADD_SCHED_SETTLE_EN
  logic [CONF_W-1:0]      last_conf;
  logic                   need_settle;

  // A conf change relative to the last executed op needs one settle cycle.
  assign need_settle = (gnt_conf != last_conf);
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  // Select the granted requester's fields using the one-hot grant.
  always_comb begin
    gnt_a    = '0;
    gnt_b    = '0;
    gnt_conf = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        gnt_a    = bus.req_a[k*OP_BITWIDTH +: OP_BITWIDTH];
        gnt_b    = bus.req_b[k*OP_BITWIDTH +: OP_BITWIDTH];
        gnt_conf = bus.req_conf[k*CONF_W +: CONF_W];
      end
    end
  end

  assign ptr_next = (op_id == ID_W'(NUM_REQ - 1)) ? '0 : op_id + ID_W'(1);

  // Next-state and per-state strobes.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    capture      = 1'b0;
    release_resp = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          accept = 1'b1;
`ifdef CONF_ADD_SCHED_SETTLE_EN
          state_nxt = need_settle ? SETTLE : EXEC;
`else
          state_nxt = EXEC;
`endif
        end
      end
`ifdef CONF_ADD_SCHED_SETTLE_EN
      SETTLE: state_nxt = EXEC;
`endif
      EXEC: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          release_resp = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operation latch on grant, result capture in EXEC, pointer advance on response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a        <= '0;
      op_b        <= '0;
      op_conf     <= '0;
      op_id       <= '0;
      resp_data_q <= '0;
      rr_ptr      <= '0;
`ifdef CONF_ADD_SCHED_SETTLE_EN
      last_conf   <= '0;
`endif
    end else begin
      if (accept) begin
        op_a    <= gnt_a;
        op_b    <= gnt_b;
        op_conf <= gnt_conf;
        op_id   <= gnt_id;
      end
      if (capture) begin
        resp_data_q <= bus.add_c;
`ifdef CONF_ADD_SCHED_SETTLE_EN
        last_conf   <= op_conf;
`endif
      end
      if (release_resp) rr_ptr <= ptr_next;
    end
  end

  // The op registers only change on a grant, so the adder inputs keep their last values otherwise.
  assign bus.add_a           = op_a;
  assign bus.add_b           = op_b;
  assign bus.add_conf_select = op_conf;

  assign bus.req_ready  = (state == IDLE) ? gnt : '0;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_id    = op_id;
  assign bus.resp_data  = resp_data_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_conf_add_sched.sv
// tb/tb_conf_add_sched.sv - directed and randomized bench for conf_add_sched with a transaction-level model
module tb_conf_add_sched;
  import conf_add_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  int n_cmp;
  int n_fail;

  // Transaction-level model state.
  int             m_ptr;
  logic [2:0]     m_last;
  logic [W-1:0]   m_a [N];
  logic [W-1:0]   m_b [N];
  logic [2:0]     m_conf [N];

  always #5 clk = ~clk;

  conf_add_sched_if #(.NUM_REQ(N), .OP_BITWIDTH(W)) bus ();

  // Exact adder stands in for the approximate one at the parent level.
  assign bus.add_c = bus.add_a + bus.add_b;

  conf_add_sched #(
    .NUM_REQ            (N),
    .OP_BITWIDTH        (W),
    .DATA_PATH_BITWIDTH (W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fields();
    for (int k = 0; k < N; k++) begin
      bus.req_a[k*W +: W]    = m_a[k];
      bus.req_b[k*W +: W]    = m_b[k];
      bus.req_conf[k*3 +: 3] = m_conf[k];
    end
  endtask

  task automatic randomize_slot(input int k);
    m_a[k]    = $urandom;
    m_b[k]    = $urandom;
    m_conf[k] = 3'($urandom_range(0, 7));
  endtask

  // First valid requester at or after the pointer, with wrap.
  function automatic int exp_grant(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_req_ready"},  64'(bus.req_ready), 64'(0));
    chk({pfx, "_resp_valid"}, 64'(bus.resp_valid), 64'(0));
    chk({pfx, "_resp_data"},  64'(bus.resp_data), 64'(0));
    chk({pfx, "_resp_id"},    64'(bus.resp_id), 64'(0));
    chk({pfx, "_busy"},       64'(busy), 64'(0));
    chk({pfx, "_add_a"},      64'(bus.add_a), 64'(0));
    chk({pfx, "_add_b"},      64'(bus.add_b), 64'(0));
    chk({pfx, "_add_conf"},   64'(bus.add_conf_select), 64'(0));
  endtask

  // One full request/response exchange; starts and ends in an idle slot.
  task automatic txn(input logic [N-1:0] mask, input int bp, input bit keep);
    int           g;
    bit           settle;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic [W-1:0] sum;
    logic [2:0]   c;
    bus.req_valid = mask;
    drive_fields();
    #1;
    g   = exp_grant(mask, m_ptr);
    ea  = m_a[g];
    eb  = m_b[g];
    sum = ea + eb;
    c   = m_conf[g];
    settle = 1'b0;
`ifdef CONF_ADD_SCHED_SETTLE_EN
    settle = (c != m_last);
`endif
    chk("grant_onehot", 64'(bus.req_ready), 64'(1) << g);
    step();
    if (keep) begin
      randomize_slot(g);
      drive_fields();
    end else begin
      bus.req_valid = '0;
    end
    chk("busy_after_accept", 64'(busy), 64'(1));
    chk("ready_low_after_accept", 64'(bus.req_ready), 64'(0));
    if (settle) begin
      chk("settle_conf", 64'(bus.add_conf_select), 64'(c));
      chk("settle_no_resp", 64'(bus.resp_valid), 64'(0));
      step();
    end
    chk("exec_add_a", 64'(bus.add_a), 64'(ea));
    chk("exec_add_b", 64'(bus.add_b), 64'(eb));
    chk("exec_conf", 64'(bus.add_conf_select), 64'(c));
    chk("exec_no_resp", 64'(bus.resp_valid), 64'(0));
    step();
    bus.resp_ready = (bp == 0);
    chk("resp_valid", 64'(bus.resp_valid), 64'(1));
    chk("resp_id", 64'(bus.resp_id), 64'(g));
    chk("resp_data", 64'(bus.resp_data), 64'(sum));
    for (int i = 0; i < bp; i++) begin
      step();
      chk("hold_valid", 64'(bus.resp_valid), 64'(1));
      chk("hold_data", 64'(bus.resp_data), 64'(sum));
      chk("hold_id", 64'(bus.resp_id), 64'(g));
      chk("hold_no_grant", 64'(bus.req_ready), 64'(0));
      if (i == bp - 1) bus.resp_ready = 1'b1;
    end
    step();
    bus.resp_ready = 1'b0;
    chk("idle_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    m_ptr  = (g + 1) % N;
    m_last = c;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      m_a[k] = '0; m_b[k] = '0; m_conf[k] = '0;
    end
    drive_fields();
    m_ptr  = 0;
    m_last = '0;
    step();
    step();
    rst = 1'b0;
    check_reset_outputs("por");

    // Single request: 5 + 7 with conf 1 from requester 0.
    m_a[0] = 32'd5; m_b[0] = 32'd7; m_conf[0] = 3'd1;
    txn(4'b0001, 0, 1'b0);

    // All requesters continuously valid from reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_ptr  = 0;
    m_last = '0;
    for (int k = 0; k < N; k++) randomize_slot(k);
    for (int i = 0; i < 5; i++) txn(4'b1111, 0, 1'b1);
    bus.req_valid = '0;

    // Overflow wraps to zero.
    m_a[1] = 32'hFFFF_FFFF; m_b[1] = 32'd1; m_conf[1] = 3'd4;
    txn(4'b0010, 0, 1'b0);

    // Five cycles of response backpressure with a competing request pending.
    randomize_slot(3);
    randomize_slot(0);
    txn(4'b1001, 5, 1'b1);
    bus.req_valid = '0;

    // Conf 1, 1, then 2: only the last one needs reconfiguration.
    m_a[2] = $urandom; m_b[2] = $urandom; m_conf[2] = 3'd1;
    txn(4'b0100, 0, 1'b0);
    m_a[2] = $urandom; m_b[2] = $urandom; m_conf[2] = 3'd1;
    txn(4'b0100, 0, 1'b0);
    m_a[2] = $urandom; m_b[2] = $urandom; m_conf[2] = 3'd2;
    txn(4'b0100, 0, 1'b0);

    // Randomized mix of masks, operands, confs and backpressure.
    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < N; k++) randomize_slot(k);
      txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'b0);
    end

    // Reset while an operation is executing.
    m_a[2] = $urandom; m_b[2] = $urandom; m_conf[2] = m_last;
    bus.req_valid = 4'b0100;
    drive_fields();
    #1;
    chk("abort_grant", 64'(bus.req_ready), 64'(1) << exp_grant(4'b0100, m_ptr));
    step();
    bus.req_valid = '0;
    chk("abort_in_exec", 64'(busy), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_ptr  = 0;
    m_last = '0;
    check_reset_outputs("abort");
    step();
    step();
    chk("abort_no_resp", 64'(bus.resp_valid), 64'(0));
    chk("abort_idle", 64'(busy), 64'(0));
    for (int k = 0; k < N; k++) randomize_slot(k);
    txn(4'b1111, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
